aes_trace_sequencer: RTL and testbench

AES_TRACE_SEQUENCER -- requirements
Module: aes_trace_sequencer

---
 rtl/aes_trace_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_aes_trace_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_trace_sequencer.sv
// aes_trace_sequencer: steps an AES core through a run of capture traces.
// Optional fixed-vs-random plaintext mode: define AES_TRACE_FVR_EN.
module aes_trace_sequencer #(
   parameter int NUM_TRACES     = 16,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int IDX_W          = 16
) (
   input  logic             AES_clk,
   input  logic             AES_rst,
   input  logic             start,
   input  logic             abort,
   input  logic [127:0]     key_in,
   input  logic [127:0]     seed_in,
   input  logic [127:0]     fixed_pt_in,
   output logic             AES_en,
   output logic [127:0]     AES_data_in,
   output logic [127:0]     AES_key_in,
   input  logic [127:0]     AES_data_out,
   input  logic             AES_data_out_valid,
   output logic             trace_trig,
   output logic [IDX_W-1:0] trace_idx,
   output logic [127:0]     cap_data,
   output logic             cap_valid,
   output logic             cap_class,
   output logic             busy,
   output logic             done,
   output logic             timeout_err
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [TMO_W-1:0] TMO_LAST =
      TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST =
      GAP_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST =
      IDX_W'(NUM_TRACES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      GAP,
      DONE
   } state_t;

   state_t           state;
   logic [127:0]     lfsr;
   logic [127:0]     lfsr_step;
   logic [127:0]     seed_eff;
   logic [TMO_W-1:0] tmo_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [IDX_W-1:0] idx_next;
   logic             run_end;

   assign lfsr_step = {lfsr[126:0],
                       lfsr[127] ^ lfsr[125] ^
                       lfsr[100] ^ lfsr[98]};

   // an all-zero seed would lock the LFSR, so it is replaced by 1
   assign seed_eff = (seed_in == '0) ? 128'h1 : seed_in;
   assign idx_next = trace_idx + IDX_W'(1);

   // a valid response wins over a timeout in the same cycle
   assign run_end  = AES_data_out_valid || (tmo_cnt == TMO_LAST);

`ifndef AES_TRACE_FVR_EN
   logic unused_fixed;
   assign unused_fixed = ^fixed_pt_in;
`endif

   // sequencer FSM; every output is a flop updated with the state
   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) begin
         state       <= IDLE;
         lfsr        <= 128'h1;
         tmo_cnt     <= '0;
         gap_cnt     <= '0;
         AES_en      <= 1'b0;
         AES_data_in <= '0;
         AES_key_in  <= '0;
         trace_trig  <= 1'b0;
         trace_idx   <= '0;
         cap_data    <= '0;
         cap_valid   <= 1'b0;
         cap_class   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         cap_valid <= 1'b0;
         done      <= 1'b0;
         if (abort) begin
            state       <= IDLE;
            AES_en      <= 1'b0;
            trace_trig  <= 1'b0;
            AES_data_in <= '0;
            busy        <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     state       <= LOAD;
                     busy        <= 1'b1;
                     trace_idx   <= '0;
                     timeout_err <= 1'b0;
                  end
               end
               LOAD: begin
                  state      <= RUN;
                  AES_key_in <= key_in;
                  lfsr       <= seed_eff;
                  AES_en     <= 1'b1;
                  trace_trig <= 1'b1;
                  tmo_cnt    <= '0;
`ifdef AES_TRACE_FVR_EN
                  AES_data_in <= fixed_pt_in;
                  cap_class   <= 1'b1;
`else
                  AES_data_in <= seed_eff;
`endif
               end
               RUN: begin
                  if (run_end) begin
                     state       <= GAP;
                     AES_en      <= 1'b0;
                     trace_trig  <= 1'b0;
                     AES_data_in <= '0;
                     gap_cnt     <= '0;
                     if (AES_data_out_valid) begin
                        cap_data  <= AES_data_out;
                        cap_valid <= 1'b1;
                     end else begin
                        timeout_err <= 1'b1;
                     end
                  end else begin
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  end
               end
               GAP: begin
                  if (gap_cnt != GAP_LAST) begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end else if (trace_idx == IDX_LAST) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state      <= RUN;
                     trace_idx  <= idx_next;
                     AES_en     <= 1'b1;
                     trace_trig <= 1'b1;
                     tmo_cnt    <= '0;
`ifdef AES_TRACE_FVR_EN
                     // odd traces are random; the first keeps the seed
                     if (idx_next[0]) begin
                        cap_class <= 1'b0;
                        if (idx_next == IDX_W'(1)) begin
                           AES_data_in <= lfsr;
                        end else begin
                           lfsr        <= lfsr_step;
                           AES_data_in <= lfsr_step;
                        end
                     end else begin
                        cap_class   <= 1'b1;
                        AES_data_in <= fixed_pt_in;
                     end
`else
                     lfsr        <= lfsr_step;
                     AES_data_in <= lfsr_step;
`endif
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// tb_aes_trace_sequencer: table, directed and random runs checked
// against a trace-level model of the sequencer.
module tb_aes_trace_sequencer;

   localparam int NT   = 3;
   localparam int GAPC = 4;
   localparam int TMO  = 8;

   localparam logic [127:0] FIXED =
      128'ha6f2daeb_140fa720_529e75d5_21cbc681;
   localparam logic [127:0] KEY0 =
      128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [127:0]     key_in = '0;
   logic [127:0]     seed_in = '0;
   logic [127:0]     fixed_pt_in = '0;
   logic [127:0]     data_out = '0;
   logic             data_out_valid = 1'b0;
   logic             AES_en;
   logic [127:0]     AES_data_in;
   logic [127:0]     AES_key_in;
   logic             trace_trig;
   logic [15:0]      trace_idx;
   logic [127:0]     cap_data;
   logic             cap_valid;
   logic             cap_class;
   logic             busy;
   logic             done;
   logic             timeout_err;

   aes_trace_sequencer #(
      .NUM_TRACES(NT),
      .GAP_CYCLES(GAPC),
      .TIMEOUT_CYCLES(TMO),
      .IDX_W(16)
   ) dut (
      .AES_clk(clk),
      .AES_rst(rst),
      .start(start),
      .abort(abort),
      .key_in(key_in),
      .seed_in(seed_in),
      .fixed_pt_in(fixed_pt_in),
      .AES_en(AES_en),
      .AES_data_in(AES_data_in),
      .AES_key_in(AES_key_in),
      .AES_data_out(data_out),
      .AES_data_out_valid(data_out_valid),
      .trace_trig(trace_trig),
      .trace_idx(trace_idx),
      .cap_data(cap_data),
      .cap_valid(cap_valid),
      .cap_class(cap_class),
      .busy(busy),
      .done(done),
      .timeout_err(timeout_err)
   );

   initial forever #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // observation state
   logic [127:0] pt_q[$];
   logic [127:0] cap_q[$];
   int           len_q[$];
   int           gap_q[$];
   int           cls_q[$];
   int           en_cnt, low_cnt, done_cnt;
   int           inv_err, first_en, ticks;
   int           lat_arr[NT];
   bit           en_prev, noise;
   logic [127:0] cur_key;

   typedef struct {
      logic [127:0] seed;
      int           l0, l1, l2;
      logic [127:0] exp_l0, exp_l1;
      bit           exp_tmo;
      int           exp_ncap;
   } vec_t;

   vec_t tbl[5];

   task automatic check(string n, logic [127:0] a,
                        logic [127:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", n, a, e);
      end
   endtask

   task automatic check_i(string n, int a, int e);
      n_chk++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", n, a, e);
      end
   endtask

   function automatic logic [127:0] xform(logic [127:0] p);
      return {p[63:0], p[127:64]} ^
             128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
   endfunction

   // plaintext of trace i from the seed and the run rules
   function automatic logic [127:0] model_pt(logic [127:0] sd,
                                             logic [127:0] fx,
                                             int i);
      logic [127:0] s;
      logic         fb;
      int           steps;
      s = (sd == 0) ? 128'h1 : sd;
`ifdef AES_TRACE_FVR_EN
      if (i % 2 == 0) return fx;
      steps = (i - 1) / 2;
`else
      steps = i;
      if (fx == 0) steps = i;
`endif
      for (int k = 0; k < steps; k++) begin
         fb = s[127] ^ s[125] ^ s[100] ^ s[98];
         s  = (s << 1) | {127'd0, fb};
      end
      return s;
   endfunction

   function automatic int model_cls(int i);
`ifdef AES_TRACE_FVR_EN
      return (i % 2 == 0) ? 1 : 0;
`else
      return (i < 0) ? 1 : 0;
`endif
   endfunction

   task automatic clear_mon();
      pt_q.delete();
      cap_q.delete();
      len_q.delete();
      gap_q.delete();
      cls_q.delete();
      en_cnt   = 0;
      low_cnt  = 0;
      done_cnt = 0;
      inv_err  = 0;
      first_en = -1;
      ticks    = 0;
      en_prev  = AES_en;
   endtask

   // one cycle: sample outputs at negedge, then drive the core model
   task automatic tick();
      int t;
      @(negedge clk);
      ticks++;
      if (trace_trig !== AES_en) inv_err++;
      if (!AES_en && AES_data_in != '0) inv_err++;
      if (AES_en && !busy) inv_err++;
      if (AES_en && !en_prev) begin
         if (pt_q.size() > 0) gap_q.push_back(low_cnt);
         else first_en = ticks;
         pt_q.push_back(AES_data_in);
         if (AES_key_in !== cur_key) inv_err++;
         en_cnt = 0;
      end
      if (AES_en) en_cnt++;
      if (!AES_en && en_prev) begin
         len_q.push_back(en_cnt);
         low_cnt = 0;
      end
      if (!AES_en) low_cnt++;
      en_prev = AES_en;
      if (cap_valid) begin
         cap_q.push_back(cap_data);
         cls_q.push_back(int'(cap_class));
      end
      if (done) done_cnt++;
      data_out_valid = 1'b0;
      data_out = {$urandom, $urandom, $urandom, $urandom};
      if (AES_en) begin
         t = pt_q.size() - 1;
         if (t < NT && lat_arr[t] != 0 &&
             en_cnt == lat_arr[t]) begin
            data_out_valid = 1'b1;
            data_out = xform(AES_data_in);
         end
      end else if (noise && $urandom_range(0, 3) == 0) begin
         data_out_valid = 1'b1;
      end
   endtask

   task automatic run_case(string tag, logic [127:0] sd,
                           logic [127:0] k, logic [127:0] fx,
                           int l0, int l1, int l2,
                           bit hold, bit nz);
      logic [127:0] exp_cap[$];
      int           exp_cls[$];
      bit           exp_tmo;
      bit           capd;
      logic [127:0] ept;
      seed_in     = sd;
      key_in      = k;
      fixed_pt_in = fx;
      cur_key     = k;
      lat_arr     = '{l0, l1, l2};
      noise       = nz;
      clear_mon();
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      check({tag, "/idx_clr"}, 128'(trace_idx), 0);
      check({tag, "/tmo_clr"}, 128'(timeout_err), 0);
      check({tag, "/busy"}, 128'(busy), 1);
      for (int c = 0; c < 400 && done_cnt == 0; c++) tick();
      start = 1'b0;
      tick();
      tick();
      check_i({tag, "/first_en"}, first_en, 2);
      check_i({tag, "/ntraces"}, pt_q.size(), NT);
      exp_tmo = 1'b0;
      for (int i = 0; i < NT; i++) begin
         capd = lat_arr[i] != 0 && lat_arr[i] <= TMO;
         ept  = model_pt(sd, fx, i);
         check($sformatf("%s/pt%0d", tag, i),
               (i < pt_q.size()) ? pt_q[i] : 'x, ept);
         check_i($sformatf("%s/len%0d", tag, i),
                 (i < len_q.size()) ? len_q[i] : -1,
                 capd ? lat_arr[i] : TMO);
         if (i > 0)
            check_i($sformatf("%s/gap%0d", tag, i),
                    (i - 1 < gap_q.size()) ? gap_q[i - 1] : -1,
                    GAPC);
         if (capd) begin
            exp_cap.push_back(xform(ept));
            exp_cls.push_back(model_cls(i));
         end else begin
            exp_tmo = 1'b1;
         end
      end
      check_i({tag, "/ncap"}, cap_q.size(), exp_cap.size());
      for (int i = 0; i < exp_cap.size(); i++) begin
         check($sformatf("%s/cap%0d", tag, i),
               (i < cap_q.size()) ? cap_q[i] : 'x, exp_cap[i]);
         check_i($sformatf("%s/cls%0d", tag, i),
                 (i < cls_q.size()) ? cls_q[i] : -1, exp_cls[i]);
      end
      check({tag, "/tmo"}, 128'(timeout_err), 128'(exp_tmo));
      check_i({tag, "/done"}, done_cnt, 1);
      check({tag, "/idx_end"}, 128'(trace_idx), 128'(NT - 1));
      check({tag, "/idle"}, 128'(busy), 0);
      check_i({tag, "/inv"}, inv_err, 0);
   endtask

   initial begin
      logic [127:0] rs, rk, rf;
      int           idle_bad;
      bit           in_gap;

      tbl[0] = '{128'h000000e5_00000000_00000000_00000000,
                 6, 6, 6,
                 128'h000000e5_00000000_00000000_00000000,
                 128'h000001ca_00000000_00000000_00000001,
                 1'b0, 3};
      tbl[1] = '{128'h1, 0, 0, 0, 128'h1, 128'h2, 1'b1, 0};
      tbl[2] = '{128'h0, 3, 8, 1, 128'h1, 128'h2, 1'b0, 3};
      tbl[3] = '{128'h80000000_00000000_00000000_00000000,
                 9, 2, 8,
                 128'h80000000_00000000_00000000_00000000,
                 128'h1, 1'b1, 2};
      tbl[4] = '{128'h20000010_00000000_00000000_00000000,
                 1, 1, 1,
                 128'h20000010_00000000_00000000_00000000,
                 128'h40000020_00000000_00000000_00000000,
                 1'b0, 3};

      noise = 1'b0;
      cur_key = '0;
      lat_arr = '{0, 0, 0};
      clear_mon();

      // reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst/en", 128'(AES_en), 0);
      check("rst/data_in", AES_data_in, 0);
      check("rst/key", AES_key_in, 0);
      check("rst/trig", 128'(trace_trig), 0);
      check("rst/idx", 128'(trace_idx), 0);
      check("rst/cap", cap_data, 0);
      check("rst/flags", {cap_valid, cap_class, busy,
                          done, timeout_err}, 0);
      rst = 1'b0;
      idle_bad = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (busy || AES_en || done) idle_bad++;
      end
      check_i("rst/no_action", idle_bad, 0);

      // table-driven runs
      for (int v = 0; v < 5; v++) begin
         run_case($sformatf("tbl%0d", v), tbl[v].seed, KEY0, FIXED,
                  tbl[v].l0, tbl[v].l1, tbl[v].l2, 1'b0, 1'b0);
`ifdef AES_TRACE_FVR_EN
         check($sformatf("tbl%0d/lit0", v),
               (pt_q.size() > 0) ? pt_q[0] : 'x, FIXED);
         check($sformatf("tbl%0d/lit1", v),
               (pt_q.size() > 1) ? pt_q[1] : 'x, tbl[v].exp_l0);
`else
         check($sformatf("tbl%0d/lit0", v),
               (pt_q.size() > 0) ? pt_q[0] : 'x, tbl[v].exp_l0);
         check($sformatf("tbl%0d/lit1", v),
               (pt_q.size() > 1) ? pt_q[1] : 'x, tbl[v].exp_l1);
`endif
         check($sformatf("tbl%0d/lit_tmo", v),
               128'(timeout_err), 128'(tbl[v].exp_tmo));
         check_i($sformatf("tbl%0d/lit_ncap", v),
                 cap_q.size(), tbl[v].exp_ncap);
      end

      // asynchronous reset in the middle of trace 1
      clear_mon();
      seed_in = 128'h1234;
      key_in = KEY0;
      cur_key = KEY0;
      lat_arr = '{2, 0, 0};
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 60 &&
           !(pt_q.size() == 2 && en_cnt >= 2); c++) tick();
      check("arst/pre_run", 128'(AES_en), 1);
      #2 rst = 1'b1;
      #1;
      check("arst/en", 128'(AES_en), 0);
      check("arst/busy", 128'(busy), 0);
      check("arst/trig", 128'(trace_trig), 0);
      check("arst/idx", 128'(trace_idx), 0);
      check("arst/data", AES_data_in, 0);
      tick();
      tick();
      rst = 1'b0;
      idle_bad = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (busy || AES_en || done) idle_bad++;
      end
      check_i("arst/no_action", idle_bad, 0);
      run_case("arst_rerun", tbl[0].seed, KEY0, FIXED,
               4, 5, 6, 1'b0, 1'b0);

      // abort in the gap after trace 1; timeout_err must survive
      clear_mon();
      seed_in = 128'h55;
      key_in = KEY0;
      cur_key = KEY0;
      lat_arr = '{0, 2, 2};
      start = 1'b1;
      tick();
      start = 1'b0;
      in_gap = 1'b0;
      for (int c = 0; c < 100 && !in_gap; c++) begin
         tick();
         in_gap = pt_q.size() == 2 && !AES_en;
      end
      check("abort/in_gap", 128'(in_gap && busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort/busy", 128'(busy), 0);
      check("abort/en", 128'(AES_en), 0);
      for (int c = 0; c < 14; c++) tick();
      check_i("abort/no_done", done_cnt, 0);
      check_i("abort/no_trace", pt_q.size(), 2);
      check("abort/tmo_kept", 128'(timeout_err), 1);
      abort = 1'b1;
      start = 1'b1;
      tick();
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("abort/beats_start", 128'(busy), 0);
      run_case("abort_rerun", 128'h77, KEY0, FIXED,
               3, 3, 3, 1'b0, 1'b1);

      // randomized runs against the model
      for (int it = 0; it < 20; it++) begin
         rs = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 4) == 0) rs = '0;
         rk = {$urandom, $urandom, $urandom, $urandom};
         rf = {$urandom, $urandom, $urandom, $urandom};
         run_case($sformatf("rnd%0d", it), rs, rk, rf,
                  int'($urandom_range(0, 10)),
                  int'($urandom_range(0, 10)),
                  int'($urandom_range(0, 10)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
